// File: rtl/key_toggle_sched_pkg.sv
// Shared definitions for the key-to-LED toggle scheduler:
// FSM state encodings and default channel count / guard time.
package key_toggle_sched_pkg;

  localparam int DEF_N    = 4;
  localparam int DEF_HOLD = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/key_toggle_sched_rr_arbiter.sv
// Combinational round-robin pick: the first set request bit at or after
// the pointer, wrapping N-1 -> 0. Indices are wrapped mod N explicitly, so a
// non-power-of-two N never produces an index >= N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  localparam int W = $clog2(N);

  logic [W:0] w_sum;

  // Scan the N candidates starting at the pointer and keep the first hit.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (W+1)'(k);
      if (w_sum >= (W+1)'(N)) begin
        w_sum = w_sum - (W+1)'(N);
      end
      if (!o_any && i_req[w_sum[W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/key_toggle_sched.sv
// Key-to-LED toggle scheduler. Latches single-cycle key pulses, serves them
// one at a time in round-robin order, toggles the mirrored LED (key i drives
// led[N-1-i]) and then waits HOLD guard cycles before the next grant.
// All outputs come straight from registers; dbg_state exposes the FSM state.
module key_toggle_sched
  import key_toggle_sched_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int HOLD = DEF_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         key_pulse,
  output logic [N-1:0]         led,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic [N-1:0]         pending,
  output logic                 drop,
  output logic [1:0]           dbg_state
);

  localparam int W  = $clog2(N);
  localparam int CW = $clog2(HOLD + 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_pending;
  logic [N-1:0]  r_led;
  logic [N-1:0]  w_served;
  logic [N-1:0]  w_led_flip;
  logic [W-1:0]  r_ptr;
  logic [W-1:0]  r_grant_idx;
  logic [W-1:0]  w_pick_idx;
  logic          w_pick_any;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_drop;

  rr_arbiter #(.N(N)) u_arb (
    .i_req (r_pending),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Channel being served this cycle (GRANT only) and its mirrored LED bit.
  always_comb begin
    w_served   = '0;
    w_led_flip = '0;
    for (int i = 0; i < N; i++) begin
      if (r_state == ST_GRANT && r_grant_idx == W'(i)) begin
        w_served[i]       = 1'b1;
        w_led_flip[N-1-i] = 1'b1;
      end
    end
  end

  // Next-state logic: IDLE -> GRANT on any pending, one GRANT cycle, then
  // HOLD until the guard counter reaches zero.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_pick_any) w_state_next = ST_GRANT;
      ST_GRANT: w_state_next = ST_HOLD;
      ST_HOLD:  if (r_cnt == '0) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register; busy is registered from the next state so it lines
  // up with the state it describes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != ST_IDLE);
    end
  end

  // Request capture: clear the served bit, OR in new pulses. A pulse on a
  // bit that is pending and not being served right now merges and flags drop;
  // a pulse on the bit being granted is a fresh request, not a drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_served) | key_pulse;
      r_drop    <= |(key_pulse & r_pending & ~w_served);
    end
  end

  // Grant index, round-robin pointer and guard counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant_idx <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
    end else begin
      if (r_state == ST_IDLE && w_pick_any) begin
        r_grant_idx <= w_pick_idx;
      end
      if (r_state == ST_GRANT) begin
        r_ptr <= (r_grant_idx == W'(N - 1)) ? '0 : r_grant_idx + W'(1);
        r_cnt <= CW'(HOLD - 1);
      end else if (r_state == ST_HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // LED register: the served channel's LED flips at the closing edge of GRANT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led <= '0;
    end else begin
      r_led <= r_led ^ w_led_flip;
    end
  end

  assign led       = r_led;
  assign busy      = r_busy;
  assign grant_idx = r_grant_idx;
  assign pending   = r_pending;
  assign drop      = r_drop;
  assign dbg_state = r_state;

endmodule
